// File: rtl/line_fifo_rdctl_pkg.sv
// Shared definitions for the line FIFO read-side sequencer.
//   state_e          : sequencer state encoding
//   PAD_BYTE_DEFAULT : byte emitted for line positions the FIFO could not supply
package line_fifo_rdctl_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned LEN_W_DEFAULT = 16;
    localparam int unsigned CNT_W_DEFAULT = 16;

    localparam logic [BYTE_W-1:0] PAD_BYTE_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // waiting for a line sync
        ST_STREAM = 2'd1,   // bytes come from the FIFO
        ST_PAD    = 2'd2,   // FIFO ran dry; remaining bytes are padding
        ST_DRAIN  = 2'd3    // last byte loaded, waiting for its handshake
    } state_e;

endpackage : line_fifo_rdctl_pkg

// File: rtl/line_fifo_rdctl.sv
// Read-side sequencer for the byte-wide FWFT line FIFO.
// On each accepted line_start it emits exactly cfg_line_len bytes on a
// registered valid/ready stream, padding with PAD_BYTE once the FIFO runs dry
// so that downstream line timing is preserved.
//
// Ports:
//   clk, rst         : read-side clock, async active-high reset
//   line_start       : single-cycle line sync request
//   cfg_line_len     : bytes per line, sampled when line_start is accepted
//   fifo_dout/empty  : FIFO head byte and empty flag
//   fifo_rd_en       : FIFO pop (combinational)
//   out_data/valid/last, out_ready : registered output byte stream
//   busy             : sequencer is not idle
//   line_done        : one-cycle pulse after a line completes
//   line_count       : lines completed since reset (wrapping)
//   underrun         : sticky, a line needed padding
//   sync_miss        : sticky, line_start arrived while busy
//   err_clr          : clears both sticky flags
module line_fifo_rdctl
    import line_fifo_rdctl_pkg::*;
#(
    parameter int unsigned       LEN_W    = LEN_W_DEFAULT,
    parameter int unsigned       CNT_W    = CNT_W_DEFAULT,
    parameter logic [BYTE_W-1:0] PAD_BYTE = PAD_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_start,
    input  logic [LEN_W-1:0]  cfg_line_len,
    input  logic [BYTE_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              line_done,
    output logic [CNT_W-1:0]  line_count,
    output logic              underrun,
    output logic              sync_miss,
    input  logic              err_clr
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [BYTE_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              line_done_q, line_done_d;
    logic [CNT_W-1:0]  line_count_q, line_count_d;
    logic              underrun_q, underrun_d;
    logic              sync_miss_q, sync_miss_d;

    logic in_line;
    logic rem_one;
    logic load_slot;
    logic final_hs;
    logic start_ok;
    logic start_len;
    logic start_zero;
    logic pad_from_empty;

    // Shared decode used by both combinational processes
    always_comb begin
        in_line        = (state_q == ST_STREAM) || (state_q == ST_PAD);
        rem_one        = (rem_q == LEN_W'(1));
        load_slot      = in_line && (!out_valid_q || out_ready) && (rem_q != '0);
        // Last byte of the line is being accepted this cycle
        final_hs       = (state_q == ST_DRAIN) && out_valid_q && out_ready && out_last_q;
        // A new line is accepted when idle, or back-to-back with the final handshake
        start_ok       = line_start && ((state_q == ST_IDLE) || final_hs);
        start_zero     = start_ok && (cfg_line_len == '0);
        start_len      = start_ok && (cfg_line_len != '0);
        pad_from_empty = load_slot && (state_q == ST_STREAM) && fifo_empty;
    end

    assign fifo_rd_en = load_slot && (state_q == ST_STREAM) && !fifo_empty;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_len) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (load_slot) begin
                    if (rem_one) begin
                        state_d = ST_DRAIN;
                    end else if (fifo_empty) begin
                        state_d = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                if (load_slot && rem_one) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (final_hs) begin
                    state_d = start_len ? ST_STREAM : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register, counters and sticky flags
    always_comb begin
        rem_d        = rem_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        line_done_d  = 1'b0;
        line_count_d = line_count_q;
        underrun_d   = underrun_q && !err_clr;
        sync_miss_d  = sync_miss_q && !err_clr;

        // Byte consumed downstream; a load below may refill the slot
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (load_slot) begin
            out_valid_d = 1'b1;
            out_data_d  = fifo_rd_en ? fifo_dout : PAD_BYTE;
            out_last_d  = rem_one;
            rem_d       = rem_q - LEN_W'(1);
        end

        // rem is zero whenever a line can be accepted, so this never races a load
        if (start_len) begin
            rem_d = cfg_line_len;
        end

        // A zero-length line and a final handshake can complete in the same cycle
        if (final_hs || start_zero) begin
            line_done_d = 1'b1;
        end
        line_count_d = line_count_q + CNT_W'(final_hs) + CNT_W'(start_zero);

        if (pad_from_empty) begin
            underrun_d = 1'b1;
        end
        if (line_start && !start_ok) begin
            sync_miss_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            line_done_q  <= 1'b0;
            line_count_q <= '0;
            underrun_q   <= 1'b0;
            sync_miss_q  <= 1'b0;
        end else begin
            rem_q        <= rem_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            line_done_q  <= line_done_d;
            line_count_q <= line_count_d;
            underrun_q   <= underrun_d;
            sync_miss_q  <= sync_miss_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign line_done  = line_done_q;
    assign line_count = line_count_q;
    assign underrun   = underrun_q;
    assign sync_miss  = sync_miss_q;
    assign busy       = (state_q != ST_IDLE);

endmodule : line_fifo_rdctl

// File: tb/tb_line_fifo_rdctl.sv
// Self-checking bench for line_fifo_rdctl. A FIFO is modelled with a queue;
// each accepted line is turned into a list of expected bytes (FIFO bytes then
// padding) and compared against the accepted output stream.
module tb_line_fifo_rdctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_start;
    logic [15:0] cfg_line_len;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        line_done;
    logic [15:0] line_count;
    logic        underrun;
    logic        sync_miss;
    logic        err_clr;

    always #5 clk = ~clk;

    line_fifo_rdctl #(.LEN_W(16), .CNT_W(16), .PAD_BYTE(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .line_start   (line_start),
        .cfg_line_len (cfg_line_len),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .line_done    (line_done),
        .line_count   (line_count),
        .underrun     (underrun),
        .sync_miss    (sync_miss),
        .err_clr      (err_clr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [7:0]  fifo_q[$];    // bytes physically in the FIFO
    logic [7:0]  avail_q[$];   // FIFO bytes not yet claimed by a line
    logic [7:0]  exp_data[$];  // remaining expected bytes of the current line
    bit          exp_pad[$];
    logic [15:0] cnt;
    bit          exp_done, exp_sync, u_known;
    bit          stalled, st_last;
    logic [7:0]  st_data;
    int          cyc, acc_cyc, first_rd, first_vld, done_cyc, line_pops, line_hs, acc_count;

    function automatic bit line_active();
        return exp_data.size() != 0;
    endfunction

    task automatic model_reset();
        exp_data.delete();
        exp_pad.delete();
        avail_q  = fifo_q;
        cnt      = '0;
        exp_done = 0;
        exp_sync = 0;
        u_known  = 0;
        stalled  = 0;
    endtask

    task automatic push_bytes(input int n, input logic [7:0] base, input bit rnd);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = rnd ? 8'($urandom) : base + 8'(i);
            fifo_q.push_back(b);
            avail_q.push_back(b);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, account for the edge
    task automatic step(input bit ls, input logic [15:0] len, input bit rdy,
                        input bit clr, input bit ls_at_end);
        bit         hs, done_now, acc, miss, act, ls_eff;
        logic [7:0] e;
        bit         ep;
        int         k, comp;
        @(negedge clk);
        check_eq("busy", busy, line_active());
        check_eq("line_done", line_done, exp_done);
        check_eq("line_count", line_count, cnt);
        check_eq("sync_miss", sync_miss, exp_sync);
        if (!line_active()) begin
            check_eq("underrun_idle", underrun, u_known);
            check_eq("valid_idle", out_valid, 0);
        end
        if (stalled) begin
            check_eq("stall_data", out_data, st_data);
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_last", out_last, st_last);
        end
        if (line_done && done_cyc < 0) done_cyc = cyc;
        if (out_valid && first_vld < 0) first_vld = cyc;

        ls_eff       = ls_at_end ? (exp_data.size() == 1 && out_valid && rdy) : ls;
        line_start   = ls_eff;
        cfg_line_len = len;
        out_ready    = rdy;
        err_clr      = clr;
        fifo_empty   = (fifo_q.size() == 0);
        fifo_dout    = fifo_empty ? 8'($urandom) : fifo_q[0];
        #1;
        if (fifo_rd_en) begin
            check_eq("rd_on_empty", fifo_empty, 0);
            if (first_rd < 0) first_rd = cyc;
        end
        if (out_valid && !out_ready) check_eq("rd_on_stall", fifo_rd_en, 0);
        if (clr) u_known = 0;

        act      = line_active();
        hs       = out_valid && out_ready;
        done_now = 0;
        if (hs) begin
            if (exp_data.size() == 0) begin
                check_eq("spurious_byte", out_valid, 0);
            end else begin
                e  = exp_data.pop_front();
                ep = exp_pad.pop_front();
                line_hs++;
                check_eq("data", out_data, e);
                check_eq("last", out_last, exp_data.size() == 0);
                if (ep) begin
                    check_eq("underrun_pad", underrun, 1);
                    u_known = 1;
                end
                done_now = (exp_data.size() == 0);
            end
        end
        comp = done_now ? 1 : 0;
        acc  = ls_eff && (!act || done_now);
        miss = ls_eff && act && !done_now;
        if (acc) begin
            acc_count++;
            acc_cyc   = cyc;
            first_rd  = -1;
            first_vld = -1;
            done_cyc  = -1;
            line_pops = 0;
            line_hs   = 0;
            if (len == 0) begin
                comp++;
            end else begin
                k = (int'(len) < avail_q.size()) ? int'(len) : avail_q.size();
                for (int i = 0; i < int'(len); i++) begin
                    if (i < k) begin
                        exp_data.push_back(avail_q.pop_front());
                        exp_pad.push_back(0);
                    end else begin
                        exp_data.push_back(8'h00);
                        exp_pad.push_back(1);
                    end
                end
            end
        end
        if (fifo_rd_en && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            line_pops++;
        end
        exp_done = (comp != 0);
        cnt      = cnt + 16'(comp);
        exp_sync = miss || (exp_sync && !clr);
        stalled  = out_valid && !out_ready;
        st_data  = out_data;
        st_last  = out_last;
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'($urandom_range(0, 9)), 1, 0, 0);
    endtask

    task automatic drain(input bit rnd_ready);
        int g = 0;
        while (line_active() && g < 1000) begin
            step(0, 16'($urandom_range(0, 9)), rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1, 0, 0);
            g++;
        end
        check_eq("line_drained", exp_data.size(), 0);
    endtask

    initial begin
        bit pat[4] = '{1, 0, 0, 1};
        int start_acc;
        int n;

        rst = 1; line_start = 0; cfg_line_len = '0; fifo_dout = '0;
        fifo_empty = 1; out_ready = 0; err_clr = 0;
        cyc = 0; acc_count = 0; first_rd = -1; first_vld = -1; done_cyc = -1;
        line_pops = 0; line_hs = 0; acc_cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_line_count", line_count, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rd_en", fifo_rd_en, 0);
        rst = 0;

        // Full line from a primed FIFO, latency and pop count
        push_bytes(8, 8'h10, 0);
        step(1, 16'd8, 1, 0, 0);
        drain(0);
        idle(1);
        check_eq("t1_rd_lat", 32'(first_rd - acc_cyc), 1);
        check_eq("t1_vld_lat", 32'(first_vld - acc_cyc), 2);
        check_eq("t1_done_lat", 32'(done_cyc - acc_cyc), 10);
        check_eq("t1_pops", 32'(line_pops), 8);

        // Underrun: 3 bytes available for a 6-byte line
        push_bytes(3, 8'hA1, 0);
        step(1, 16'd6, 1, 0, 0);
        drain(0);
        idle(1);
        check_eq("t2_pops", 32'(line_pops), 3);
        check_eq("t2_underrun", underrun, 1);
        step(0, 16'd0, 1, 1, 0);
        idle(1);
        push_bytes(2, 8'h55, 0);
        step(1, 16'd2, 1, 0, 0);
        drain(0);
        idle(1);
        check_eq("t2_next_pops", 32'(line_pops), 2);

        // Backpressure 1,0,0,1
        push_bytes(4, 8'hC0, 0);
        step(1, 16'd4, 1, 0, 0);
        n = 0;
        while (line_active() && n < 100) begin
            step(0, 16'd7, pat[n % 4], 0, 0);
            n++;
        end
        check_eq("t3_accepted", 32'(line_hs), 4);
        idle(1);

        // Sync miss, clear, set-wins-over-clear, back-to-back start
        push_bytes(6, 8'h30, 0);
        step(1, 16'd6, 1, 0, 0);
        idle(2);
        step(1, 16'd3, 1, 0, 0);
        drain(0);
        idle(1);
        check_eq("t4_miss", sync_miss, 1);
        step(0, 16'd0, 1, 1, 0);
        idle(1);
        push_bytes(6, 8'h40, 0);
        step(1, 16'd6, 1, 0, 0);
        idle(1);
        step(1, 16'd5, 1, 1, 0);
        drain(0);
        idle(1);
        check_eq("t4_set_wins", sync_miss, 1);
        step(0, 16'd0, 1, 1, 0);
        push_bytes(7, 8'h60, 0);
        step(1, 16'd4, 1, 0, 0);
        start_acc = acc_count;
        n = 0;
        while (line_active() && n < 100) begin
            step(0, 16'd3, 1, 0, acc_count == start_acc);
            n++;
        end
        idle(1);
        check_eq("t4_b2b_lines", 32'(acc_count - start_acc), 1);
        check_eq("t4_b2b_nomiss", sync_miss, 0);

        // Zero-length lines and counter wrap
        step(1, 16'd0, 1, 0, 0);
        idle(1);
        n = 32'(16'hFFFF - cnt);
        for (int i = 0; i < n; i++) step(1, 16'd0, 1, 0, 0);
        idle(1);
        check_eq("t5_at_max", line_count, 16'hFFFF);
        step(1, 16'd0, 1, 0, 0);
        idle(1);
        check_eq("t5_wrapped", line_count, 0);

        // Reset mid-line
        push_bytes(4, 8'h70, 0);
        step(1, 16'd10, 1, 0, 0);
        idle(3);
        @(negedge clk);
        line_start = 0;
        out_ready  = 1;
        rst        = 1;
        #1;
        check_eq("t6_valid", out_valid, 0);
        check_eq("t6_data", out_data, 0);
        check_eq("t6_last", out_last, 0);
        check_eq("t6_done", line_done, 0);
        check_eq("t6_count", line_count, 0);
        check_eq("t6_underrun", underrun, 0);
        check_eq("t6_busy", busy, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            fifo_empty = (fifo_q.size() == 0);
            #1;
            check_eq("t6_rd_in_rst", fifo_rd_en, 0);
        end
        @(negedge clk);
        rst = 0;
        model_reset();
        push_bytes(3, 8'h90, 0);
        step(1, 16'd3, 1, 0, 0);
        drain(0);
        idle(1);

        // Randomized lines: backpressure, misses, back-to-back starts, clears
        for (int l = 0; l < 120; l++) begin
            push_bytes($urandom_range(0, 10), 8'h00, 1);
            step(1, 16'($urandom_range(0, 10)), $urandom_range(0, 3) != 0, 0, 0);
            n = 0;
            while (line_active() && n < 1000) begin
                step($urandom_range(0, 19) == 0, 16'($urandom_range(0, 10)),
                     $urandom_range(0, 3) != 0, 0, $urandom_range(0, 7) == 0);
                n++;
            end
            check_eq("rnd_drained", exp_data.size(), 0);
            step(0, 16'($urandom), 1, $urandom_range(0, 3) == 0, 0);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_line_fifo_rdctl
